exp_pair_fifo: RTL and testbench
================================

# exp_pair_fifo

Elastic drain-side buffer for the floating-point multiplier's 9-bit exponent-pair pipeline. It accepts operand-exponent pairs from the upstream pipeline register stage with a valid/ready handshake. It stores up to DEPTH pairs in arrival order and presents the oldest pair to the exponent-add stage in first-word-fall-through form. This lets the downstream stage stall without losing pairs already launched into the pipeline.

## Interface
Parameters:
- WIDTH, 9, bit width of each exponent field (a and b).
- DEPTH, 4, number of pair entries; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream presents a pair on in_a/in_b.
- in_a  input  WIDTH  exponent of operand A.
- in_b  input  WIDTH  exponent of operand B.
- in_ready  output  1  buffer can accept a pair this cycle.
- out_valid  output  1  head pair is valid on out_a/out_b.
- out_a  output  WIDTH  head exponent A.
- out_b  output  WIDTH  head exponent B.
- out_ready  input  1  downstream consumes the head pair this cycle.
- count  output  log2(DEPTH)+1  number of stored pairs, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

## Operation
- Push: on a clock edge where in_valid && in_ready, the entry at wr_ptr is written with {in_a, in_b}, and wr_ptr increments.
- Pop: on a clock edge where out_valid && out_ready, rd_ptr increments.
- Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no special case.
- count behaviour:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or when idle.
- in_ready = !full. There is no bypass: when full, a same-cycle pop does not enable a push. in_ready rises in the cycle after the pop.
- out_valid = !empty. There is no pass-through: a pair written into an empty buffer becomes visible one cycle after the push edge.
- out_a/out_b are driven from storage[rd_ptr] (first-word fall-through) and hold stable while out_valid && !out_ready.
- When empty, out_a/out_b show storage[rd_ptr], which is stale data. Consumers must qualify them with out_valid.
- in_a/in_b are ignored when in_valid is low. out_ready is ignored when out_valid is low.
- Storage entries are not reset. After reset, their contents are don't-care until written.

## Timing
- Reset (rst_n low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, full = 0, in_ready = 1, out_valid = 0.
  - Takes effect immediately, with no clock required.
- Reset asserted mid-operation discards all stored pairs. No push or pop occurs on the edge where rst_n is low.
- Reset release: the first push may be taken on the first rising edge with rst_n high.
- Latency from push edge to out_valid = 1: 1 cycle (empty buffer case).
- Sustained throughput is 1 pair per cycle when out_ready is held high. count stays constant under simultaneous push and pop.
- in_ready, out_valid, full, empty and count are functions of registered state only. They have no combinational path from in_valid or out_ready.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n = 0 mid-cycle while count = 3.
  - Required: count = 0, empty = 1, in_ready = 1, out_valid = 0, immediately and before the next edge.
- Single pass-through:
  - Stimulus: push a = 9'h07F, b = 9'h081 into an empty buffer with out_ready = 1.
  - Required: out_valid = 1 one cycle later with out_a = 9'h07F, out_b = 9'h081. The pair is popped on that edge, and count returns to 0.
- Fill and back-pressure:
  - Stimulus: hold out_ready = 0 and push pairs (1,2), (3,4), (5,6), (7,8), then keep in_valid = 1 with (9,10).
  - Required: full = 1, in_ready = 0, count = 4. Pair (9,10) is not accepted. out_a/out_b hold (1,2).
- Full with pop, no bypass:
  - Stimulus: from the full state, set out_ready = 1 for one cycle with in_valid = 1.
  - Required: no push on that edge. count = 3 next cycle, in_ready = 1, head = (3,4). The next edge accepts (9,10).
- Wrap-around streaming:
  - Stimulus: hold in_valid = out_ready = 1 and stream 10 pairs a = 0..9, b = 9'h1FF − a.
  - Required: outputs appear in order, each one cycle after its push. count ≤ 1 throughout. Pointers wrap twice.
- Random handshake:
  - Stimulus: randomised in_valid/out_ready over 1000 cycles.
  - Required: a scoreboard checks FIFO order, and count always equals pushes minus pops, within 0..4.

Source files
------------

// File: rtl/exp_pair_fifo.sv
// exp_pair_fifo: first-word-fall-through FIFO holding {a, b} exponent pairs
// between the multiplier's pipeline register stage and the exponent-add stage.
// Flags come from registered state only. There is no bypass and no
// pass-through path.
module exp_pair_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_a,
    output logic [WIDTH-1:0]         out_b,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               push, pop;

    // Flags: DEPTH is a power of two, so the count MSB is set only at DEPTH.
    assign full      = count_q[AW];
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Head of the queue is always presented. It is stale when empty.
    assign out_a = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
    assign out_b = mem_q[rd_ptr_q][WIDTH-1:0];

    // Next-state for pointers and occupancy. Pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state. Async reset discards every stored pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pair storage. No reset: entries are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
    end

endmodule

// File: tb/tb_exp_pair_fifo.sv
// Bench for exp_pair_fifo. A queue-based reference model is compared against
// the DUT on every falling edge, using directed and random handshakes.
module tb_exp_pair_fifo;

    localparam int W = 9;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_a, in_b, out_a, out_b;
    logic [2:0]   count;
    logic         full, empty;

    int vectors = 0;
    int miscompares = 0;
    logic [2*W-1:0] model[$];

    exp_pair_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n = model.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == D));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("in_ready", 32'(in_ready), 32'(n < D));
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        if (n > 0) begin
            chk("out_a", 32'(out_a), 32'(model[0][2*W-1:W]));
            chk("out_b", 32'(out_b), 32'(model[0][W-1:0]));
        end
    endtask

    // One cycle: check at negedge, drive, clock, then update the model.
    task automatic cyc(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ordy);
        bit do_push, do_pop;
        check_outputs();
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        do_push = iv && (model.size() < D);
        do_pop  = ordy && (model.size() > 0);
        @(posedge clk);
        if (do_pop)  void'(model.pop_front());
        if (do_push) model.push_back({a, b});
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < D + 1; i++) cyc(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Single pass-through
        cyc(1'b1, 9'h07F, 9'h081, 1'b1);
        chk("pt_valid", 32'(out_valid), 32'd1);
        chk("pt_a", 32'(out_a), 32'h07F);
        chk("pt_b", 32'(out_b), 32'h081);
        cyc(1'b0, '0, '0, 1'b1);
        chk("pt_count0", 32'(count), 32'd0);

        // Fill and back-pressure
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(2*i+1), W'(2*i+2), 1'b0);
        cyc(1'b1, 9'd9, 9'd10, 1'b0);
        cyc(1'b1, 9'd9, 9'd10, 1'b0);
        chk("bp_full", 32'(full), 32'd1);
        chk("bp_head_a", 32'(out_a), 32'd1);
        chk("bp_head_b", 32'(out_b), 32'd2);

        // Full with pop: the push must wait a cycle
        cyc(1'b1, 9'd9, 9'd10, 1'b1);
        chk("np_count", 32'(count), 32'd3);
        chk("np_ready", 32'(in_ready), 32'd1);
        chk("np_head_a", 32'(out_a), 32'd3);
        cyc(1'b1, 9'd9, 9'd10, 1'b0);
        chk("np_accept", 32'(count), 32'd4);
        drain();

        // Wrap-around streaming
        for (int a = 0; a < 10; a++) begin
            cyc(1'b1, W'(a), W'(9'h1FF - a), 1'b1);
            chk("st_cnt_le1", 32'(count <= 1), 32'd1);
        end
        drain();

        // Random handshake
        for (int i = 0; i < 1000; i++) begin
            cyc(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                1'($urandom_range(0, 1)));
            chk("rnd_range", 32'(count <= D), 32'd1);
        end
        drain();

        // Mid-cycle reset with three pairs stored
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(i + 20), W'(i + 40), 1'b0);
        check_outputs();
        in_valid = 1'b1; in_a = 9'h055; in_b = 9'h0AA; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model.delete();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        cyc(1'b1, 9'h123, 9'h0EE, 1'b0);
        chk("post_rst_push", 32'(count), 32'd1);
        drain();
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
